uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: frame data bits; equals DFIFO_DATA_WIDTH.
REQ-002 SHALL have parameter DIV_WIDTH, default 16: width of the baud divisor.
REQ-003 SHALL have port i_apb_pclk, input, 1: the single clock.
REQ-004 SHALL have port i_apb_preset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_tx_en, input, 1: transmit enable from regmap.
REQ-006 SHALL have port i_baud_div, input, DIV_WIDTH: bit period is i_baud_div+1 clocks.
REQ-007 SHALL have ports i_parity_en, i_parity_odd and i_stop2, inputs, 1 each: frame format controls.
REQ-008 SHALL have port i_cts, input, 1: 1 = remote side may accept a new frame.
REQ-009 SHALL have port i_dfifo_empty, input, 1: downstream FIFO empty.
REQ-010 SHALL have port i_dfifo_rdata, input, DATA_WIDTH: FIFO read data, valid one clock after o_dfifo_read_req.
REQ-011 SHALL have port o_dfifo_read_req, output, 1: FIFO pop, one-clock pulse.
REQ-012 SHALL have port o_tx, output, 1: serial line, idle high, registered.
REQ-013 SHALL have port o_tx_busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port o_tx_done, output, 1: one-clock pulse at end of frame.

Function
REQ-015 SHALL implement the states IDLE, FETCH, START, DATA, PARITY and STOP.
REQ-016 IDLE: o_dfifo_read_req SHALL be asserted combinationally when i_tx_en & i_cts & !i_dfifo_empty, with the next state FETCH; otherwise the FSM SHALL stay in IDLE.
REQ-017 FETCH (one clock): SHALL capture i_dfifo_rdata into the shift register, latch i_baud_div, i_parity_en, i_parity_odd and i_stop2 for the whole frame, then go to START.
REQ-018 Config changes mid-frame SHALL NOT affect the current frame.
REQ-019 The baud counter SHALL load the latched divisor on entry to each bit and decrement each clock; the bit ends when the counter is 0.
REQ-020 A divisor of 0 SHALL give one clock per bit.
REQ-021 START SHALL drive o_tx=0 for one bit period.
REQ-022 DATA SHALL drive DATA_WIDTH bits LSB first, using a bit index 0..DATA_WIDTH-1 that leaves after the last bit.
REQ-023 After DATA, the FSM SHALL go to PARITY if parity is enabled, else to STOP.
REQ-024 The parity bit SHALL equal XOR of the data bits (even), inverted when i_parity_odd.
REQ-025 STOP SHALL drive o_tx=1 for 1 bit period, or 2 bit periods when stop2 is latched.
REQ-026 o_tx_done SHALL pulse on the last clock of STOP, with the next state IDLE.
REQ-027 First-frame latency: a read_req in cycle t SHALL give FETCH at t+1 and o_tx=0 from t+2.
REQ-028 Back-to-back frames SHALL have exactly 2 clocks of high line (IDLE, FETCH) between the stop end and the next start.
REQ-029 If i_tx_en or i_cts is deasserted mid-frame, the frame SHALL complete and no new fetch SHALL occur until both are high.
REQ-030 If the FIFO is empty in IDLE, the FSM SHALL remain in IDLE with no read_req; a read_req SHALL never be issued when empty.

Reset
REQ-031 On i_apb_preset, in any state including mid-frame, the next clock SHALL give state IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, o_dfifo_read_req=0, and zero counters and shift register.
REQ-032 A frame interrupted by reset SHALL be abandoned and its byte lost.

Structure
REQ-033 The state enum type tx_state_t and DFIFO_DATA_WIDTH SHALL live in uart_pkg.
REQ-034 The baud counter SHALL be sub-module uart_baud_cnt (load, decrement, zero flag).
REQ-035 The block SHALL be instantiated in uart_top between the downstream FIFO and o_tx, driving tx_status from o_tx_busy.

Verification
REQ-036 div=3, data 0x55, no parity, 1 stop -> o_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 clocks; o_tx_done pulse 40 clocks after start begins.
REQ-037 div=0, parity even with 0x07 -> parity bit 1; odd with 0x07 -> 0; even with 0x00 -> 0.
REQ-038 Two bytes 0xA5, 0x3C queued, div=0 -> two read_req pulses, 2-clock high gap, second frame bits match 0x3C LSB first.
REQ-039 i_cts dropped during DATA of the first of two queued bytes -> first frame completes, o_tx_done pulses, no read_req until i_cts=1, then the second frame starts 2 clocks later.
REQ-040 i_apb_preset asserted during DATA bit 3 -> next clock o_tx=1, busy=0; after release with an empty FIFO the line stays idle.
REQ-041 div=1, stop2=1 -> stop phase high for 4 clocks before o_tx_done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and widths used by the transmit scheduler and its wrapper.
package uart_pkg;

    localparam int DFIFO_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: loads a divisor, counts down to zero and holds there.
module uart_baud_cnt #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] load_val_i,
    output logic                 zero_o
);

    logic [DIV_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uart_top.sv
// UART transmit path: small downstream FIFO feeding the transmit scheduler.
module uart_top import uart_pkg::*; #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        wr_en_i,
    input  logic [DFIFO_DATA_WIDTH-1:0] wr_data_i,
    output logic                        full_o,
    input  logic                        tx_en_i,
    input  logic [DIV_WIDTH-1:0]        baud_div_i,
    input  logic                        parity_en_i,
    input  logic                        parity_odd_i,
    input  logic                        stop2_i,
    input  logic                        cts_i,
    output logic                        tx_o,
    output logic                        tx_status_o,
    output logic                        tx_done_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [DFIFO_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic [DFIFO_DATA_WIDTH-1:0] rdata_q;
    logic                        push, pop, empty;

    assign full_o = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign push   = wr_en_i && !full_o;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Read data is registered so it is valid the clock after the pop request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rdata_q  <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    uart_tx_sched #(
        .DATA_WIDTH (DFIFO_DATA_WIDTH),
        .DIV_WIDTH  (DIV_WIDTH)
    ) u_tx_sched (
        .i_apb_pclk       (clk_i),
        .i_apb_preset     (rst_i),
        .i_tx_en          (tx_en_i),
        .i_baud_div       (baud_div_i),
        .i_parity_en      (parity_en_i),
        .i_parity_odd     (parity_odd_i),
        .i_stop2          (stop2_i),
        .i_cts            (cts_i),
        .i_dfifo_empty    (empty),
        .i_dfifo_rdata    (rdata_q),
        .o_dfifo_read_req (pop),
        .o_tx             (tx_o),
        .o_tx_busy        (tx_status_o),
        .o_tx_done        (tx_done_o)
    );

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: pops one byte from the downstream FIFO and serialises it.
//   state  | meaning
//   IDLE   | line high, waiting for enable, CTS and a non-empty FIFO
//   FETCH  | capture FIFO data and latch the frame format
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | optional parity bit
//   STOP   | one or two stop bits (high)
module uart_tx_sched import uart_pkg::*; #(
    parameter int DATA_WIDTH = DFIFO_DATA_WIDTH,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  i_apb_pclk,
    input  logic                  i_apb_preset,
    input  logic                  i_tx_en,
    input  logic [DIV_WIDTH-1:0]  i_baud_div,
    input  logic                  i_parity_en,
    input  logic                  i_parity_odd,
    input  logic                  i_stop2,
    input  logic                  i_cts,
    input  logic                  i_dfifo_empty,
    input  logic [DATA_WIDTH-1:0] i_dfifo_rdata,
    output logic                  o_dfifo_read_req,
    output logic                  o_tx,
    output logic                  o_tx_busy,
    output logic                  o_tx_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic                  tx_q, tx_d;

    logic                  cnt_load;
    logic [DIV_WIDTH-1:0]  cnt_load_val;
    logic                  cnt_zero;
    logic                  read_req;
    logic                  done;

    uart_baud_cnt #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_cnt (
        .clk_i      (i_apb_pclk),
        .rst_i      (i_apb_preset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        stop_idx_d   = stop_idx_q;
        div_d        = div_q;
        par_en_d     = par_en_q;
        par_bit_d    = par_bit_q;
        stop2_d      = stop2_q;
        cnt_load     = 1'b0;
        cnt_load_val = div_q;
        read_req     = 1'b0;
        done         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_tx_en && i_cts && !i_dfifo_empty && !i_apb_preset) begin
                    read_req = 1'b1;
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                // Frame format is frozen here; the counter is primed straight from the input.
                shift_d      = i_dfifo_rdata;
                div_d        = i_baud_div;
                par_en_d     = i_parity_en;
                par_bit_d    = (^i_dfifo_rdata) ^ i_parity_odd;
                stop2_d      = i_stop2;
                cnt_load     = 1'b1;
                cnt_load_val = i_baud_div;
                state_d      = START;
            end
            START: begin
                if (cnt_zero) begin
                    cnt_load  = 1'b1;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    shift_d  = shift_q >> 1;
                    if (bit_idx_q == LAST_IDX) begin
                        stop_idx_d = 1'b0;
                        state_d    = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (cnt_zero) begin
                    cnt_load   = 1'b1;
                    stop_idx_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    if (stop2_q && !stop_idx_q) begin
                        cnt_load   = 1'b1;
                        stop_idx_d = 1'b1;
                    end else begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line value is registered against the state being entered, so o_tx tracks state_q.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_bit_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_apb_pclk) begin
        if (i_apb_preset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            div_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            div_q      <= div_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
        end
    end

    assign o_dfifo_read_req = read_req;
    assign o_tx             = tx_q;
    assign o_tx_busy        = (state_q != IDLE);
    assign o_tx_done        = done;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a behavioural downstream FIFO.
module tb_uart_tx_sched;

    logic        clk;
    logic        preset;
    logic        tx_en;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        cts;
    logic        dfifo_empty;
    logic [7:0]  dfifo_rdata;
    logic        read_req;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    int n_assert = 0;
    int n_fail   = 0;
    int drop_cts_at = -1;

    logic [7:0] fmem [16];
    int wr_n = 0;
    int rd_n = 0;
    int nreq = 0;

    uart_tx_sched #(
        .DATA_WIDTH (8),
        .DIV_WIDTH  (16)
    ) dut (
        .i_apb_pclk       (clk),
        .i_apb_preset     (preset),
        .i_tx_en          (tx_en),
        .i_baud_div       (baud_div),
        .i_parity_en      (parity_en),
        .i_parity_odd     (parity_odd),
        .i_stop2          (stop2),
        .i_cts            (cts),
        .i_dfifo_empty    (dfifo_empty),
        .i_dfifo_rdata    (dfifo_rdata),
        .o_dfifo_read_req (read_req),
        .o_tx             (tx),
        .o_tx_busy        (tx_busy),
        .o_tx_done        (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dfifo_empty = (rd_n >= wr_n);

    always @(posedge clk) begin
        if (read_req) begin
            dfifo_rdata <= fmem[rd_n[3:0]];
            rd_n        <= rd_n + 1;
            nreq        <= nreq + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_n[3:0]] = b;
        wr_n++;
    endtask

    task automatic wait_start(input string tag, input int max_cycles);
        int i = 0;
        while (tx !== 1'b0 && i < max_cycles) begin
            tick();
            i++;
        end
        chk({tag, "_start_seen"}, tx, 1'b0);
    endtask

    // Entered on the first START clock; leaves on the last STOP clock.
    task automatic frame_check(input string tag, input int div, input logic [7:0] data,
                               input bit pe, input bit par_bit, input bit s2);
        logic eb [12];
        logic tx_s [64];
        logic done_s [64];
        int nb, per, total;
        eb[0] = 1'b0;
        for (int i = 0; i < 8; i++) eb[1+i] = data[i];
        nb = 9;
        if (pe) begin eb[nb] = par_bit; nb++; end
        eb[nb] = 1'b1; nb++;
        if (s2) begin eb[nb] = 1'b1; nb++; end
        per   = div + 1;
        total = nb * per;
        for (int k = 0; k < total; k++) begin
            if (k > 0) tick();
            tx_s[k]   = tx;
            done_s[k] = tx_done;
            if (k == drop_cts_at) cts = 1'b0;
        end
        for (int b = 0; b < nb; b++) begin
            chk($sformatf("%s_bit%0d_first", tag, b), tx_s[b*per], eb[b]);
            chk($sformatf("%s_bit%0d_last", tag, b), tx_s[b*per+per-1], eb[b]);
        end
        chk({tag, "_done_pulse"}, done_s[total-1], 1'b1);
        if (total > 1) chk({tag, "_done_early"}, done_s[total-2], 1'b0);
    endtask

    initial begin
        int req_before;
        preset     = 1'b1;
        tx_en      = 1'b0;
        baud_div   = 16'd0;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        cts        = 1'b0;
        tick();
        tick();
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_done", tx_done, 1'b0);
        chk("rst_req", read_req, 1'b0);
        preset = 1'b0;
        tick();
        chk("idle_empty_req", read_req, 1'b0);

        // div=3, 0x55, no parity, one stop; format changed mid-frame must not matter
        baud_div = 16'd3;
        tx_en    = 1'b1;
        cts      = 1'b1;
        push(8'h55);
        #1;
        chk("t1_req", read_req, 1'b1);
        tick();
        chk("t1_fetch_tx", tx, 1'b1);
        chk("t1_fetch_busy", tx_busy, 1'b1);
        chk("t1_fetch_req", read_req, 1'b0);
        tick();
        chk("t1_start_tx", tx, 1'b0);
        baud_div  = 16'd0;
        parity_en = 1'b1;
        stop2     = 1'b1;
        frame_check("t1", 3, 8'h55, 1'b0, 1'b0, 1'b0);
        parity_en = 1'b0;
        stop2     = 1'b0;
        tick();
        chk("t1_idle_busy", tx_busy, 1'b0);
        chk("t1_idle_tx", tx, 1'b1);

        // parity cases at div=0
        baud_div   = 16'd0;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        push(8'h07);
        wait_start("t2a", 10);
        frame_check("t2a", 0, 8'h07, 1'b1, 1'b1, 1'b0);
        parity_odd = 1'b1;
        push(8'h07);
        wait_start("t2b", 10);
        frame_check("t2b", 0, 8'h07, 1'b1, 1'b0, 1'b0);
        parity_odd = 1'b0;
        push(8'h00);
        wait_start("t2c", 10);
        frame_check("t2c", 0, 8'h00, 1'b1, 1'b0, 1'b0);
        parity_en = 1'b0;

        // back-to-back frames
        req_before = nreq;
        push(8'hA5);
        push(8'h3C);
        wait_start("t3a", 10);
        frame_check("t3a", 0, 8'hA5, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t3_gap1_tx", tx, 1'b1);
        chk("t3_gap1_req", read_req, 1'b1);
        tick();
        chk("t3_gap2_tx", tx, 1'b1);
        chk("t3_gap2_req", read_req, 1'b0);
        tick();
        chk("t3_second_start", tx, 1'b0);
        frame_check("t3b", 0, 8'h3C, 1'b0, 1'b0, 1'b0);
        chk("t3_req_count", nreq - req_before, 2);

        // CTS dropped during DATA of the first frame
        tick();
        req_before = nreq;
        push(8'h81);
        push(8'h42);
        wait_start("t4a", 10);
        drop_cts_at = 3;
        frame_check("t4a", 0, 8'h81, 1'b0, 1'b0, 1'b0);
        drop_cts_at = -1;
        tick();
        chk("t4_idle_busy", tx_busy, 1'b0);
        chk("t4_idle_req", read_req, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("t4_held_req", read_req, 1'b0);
        chk("t4_req_count", nreq - req_before, 1);
        cts = 1'b1;
        #1;
        chk("t4_resume_req", read_req, 1'b1);
        tick();
        chk("t4_fetch_tx", tx, 1'b1);
        tick();
        chk("t4_second_start", tx, 1'b0);
        frame_check("t4b", 0, 8'h42, 1'b0, 1'b0, 1'b0);

        // reset during DATA bit 3
        push(8'hF0);
        wait_start("t5", 10);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_bit3_tx", tx, 1'b0);
        chk("t5_bit3_busy", tx_busy, 1'b1);
        preset = 1'b1;
        tick();
        chk("t5_rst_tx", tx, 1'b1);
        chk("t5_rst_busy", tx_busy, 1'b0);
        chk("t5_rst_done", tx_done, 1'b0);
        chk("t5_rst_req", read_req, 1'b0);
        preset = 1'b0;
        req_before = nreq;
        for (int i = 0; i < 6; i++) tick();
        chk("t5_after_tx", tx, 1'b1);
        chk("t5_after_busy", tx_busy, 1'b0);
        chk("t5_after_req", nreq - req_before, 0);

        // transmit disabled with data queued
        tx_en = 1'b0;
        push(8'h99);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_dis_req", read_req, 1'b0);
        chk("t6_dis_busy", tx_busy, 1'b0);

        // div=1 with two stop bits
        baud_div = 16'd1;
        stop2    = 1'b1;
        tx_en    = 1'b1;
        #1;
        chk("t6_en_req", read_req, 1'b1);
        wait_start("t6", 10);
        frame_check("t6", 1, 8'h99, 1'b0, 1'b0, 1'b1);
        tick();
        chk("t6_end_busy", tx_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
